// File: rtl/seq_generator.sv
// Serial bit-pattern transmitter: sends the low len bits of a captured pattern
// MSB-first, repeated reps times (0 = forever) with GAP idle cycles between repeats.
module seq_generator #(
  parameter int W   = 8,
  parameter int RW  = 4,
  parameter int GAP = 1,
  localparam int LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  pattern,
  input  logic [LW-1:0] len,
  input  logic [RW-1:0] reps,
  input  logic          stop,
  output logic          dout,
  output logic          dvalid,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_GAP  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t        st;
  logic [W-1:0]  pat_q;     // captured pattern, left-aligned so bit W-1 is sent first
  logic [W-1:0]  sh_q;      // bits still to send in the current repetition
  logic [LW-1:0] len_q;
  logic [LW-1:0] bit_cnt;
  logic [RW-1:0] rep_cnt;
  logic          cont_q;
  logic [GCW-1:0] gap_cnt;

  logic          len_ok;
  logic [W-1:0]  aligned;
  logic          last_bit;
  logic          more_reps;

  assign len_ok    = (len != '0) && (len <= LW'(W));
  assign aligned   = pattern << (LW'(W) - len);
  assign last_bit  = (bit_cnt == len_q - 1'b1);
  assign more_reps = cont_q || (rep_cnt > RW'(1));
  assign state     = st;

  // NOTE: all state, including the shift registers, uses non-blocking assignments
  // and is cleared by the synchronous reset so a mid-stream rst leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      cont_q  <= 1'b0;
      gap_cnt <= '0;
      dout    <= 1'b0;
      dvalid  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (stop) begin
      // Abort wins over start and normal sequencing; never produces done.
      st     <= S_IDLE;
      dout   <= 1'b0;
      dvalid <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          done <= 1'b0;
          if (start && len_ok) begin
            st      <= S_SEND;
            pat_q   <= aligned;
            sh_q    <= aligned << 1;
            dout    <= aligned[W-1];
            dvalid  <= 1'b1;
            busy    <= 1'b1;
            len_q   <= len;
            rep_cnt <= reps;
            cont_q  <= (reps == '0);
            bit_cnt <= '0;
          end
        end

        S_SEND: begin
          if (!last_bit) begin
            dout    <= sh_q[W-1];
            sh_q    <= sh_q << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end else if (more_reps) begin
            if (!cont_q) rep_cnt <= rep_cnt - 1'b1;
            bit_cnt <= '0;
            if (GAP > 0) begin
              st      <= S_GAP;
              dout    <= 1'b0;
              dvalid  <= 1'b0;
              gap_cnt <= '0;
            end else begin
              dout <= pat_q[W-1];
              sh_q <= pat_q << 1;
            end
          end else begin
            st     <= S_DONE;
            dout   <= 1'b0;
            dvalid <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt == GCW'(GAP - 1)) begin
            st     <= S_SEND;
            dout   <= pat_q[W-1];
            sh_q   <= pat_q << 1;
            dvalid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        S_DONE: begin
          st   <= S_IDLE;
          done <= 1'b0;
        end

        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// Scoreboard bench for seq_generator: one instance with GAP=1 (g1) and one with
// GAP=0 (g0); expected bits are queued at start, monitors pop on every dvalid cycle.
module tb_seq_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stop = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;

  logic       dout0, dvalid0, busy0, done0;
  logic [1:0] state0;
  logic       dout1, dvalid1, busy1, done1;
  logic [1:0] state1;

  always #5 clk = ~clk;

  seq_generator #(.W(8), .RW(4), .GAP(1)) dut_g1 (
    .clk(clk), .rst(rst), .start(start1), .pattern(pattern), .len(len), .reps(reps),
    .stop(stop), .dout(dout1), .dvalid(dvalid1), .busy(busy1), .done(done1), .state(state1)
  );

  seq_generator #(.W(8), .RW(4), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .start(start0), .pattern(pattern), .len(len), .reps(reps),
    .stop(stop), .dout(dout0), .dvalid(dvalid0), .busy(busy0), .done(done0), .state(state0)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit q0[$];
  bit q1[$];
  int exp_done0 = 0, exp_done1 = 0;
  int ndone0 = 0, ndone1 = 0;

  bit       det_en = 1'b0;
  logic [2:0] det_hist = '0;
  int       det_idx = 0;
  int       det_hits[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every bit the DUT presents must match the queue head.
  always @(negedge clk) begin
    if (!rst && dvalid1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL g1_unexpected_bit: got dout=%0b, expected no bit (t=%0t)", dout1, $time);
      end else check("g1_dout", dout1, q1.pop_front());
    end
    if (!rst && done1) ndone1++;
  end

  always @(negedge clk) begin
    if (!rst && dvalid0) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL g0_unexpected_bit: got dout=%0b, expected no bit (t=%0t)", dout0, $time);
      end else check("g0_dout", dout0, q0.pop_front());
    end
    if (!rst && busy0) check("g0_no_bubble", dvalid0, 1);
    if (!rst && done0) ndone0++;
  end

  // Loopback partner: overlapping 101 detector on the g1 stream.
  always @(negedge clk) begin
    if (det_en && dvalid1) begin
      det_hist = {det_hist[1:0], dout1};
      det_idx++;
      if (det_idx >= 3 && det_hist == 3'b101) det_hits.push_back(det_idx);
    end
  end

  task automatic run_job(input bit sel0, input logic [7:0] pat, input logic [3:0] ln,
                         input logic [3:0] rp, input int exp_busy, input bit poke);
    int  busy_cnt;
    bit  got_done;
    for (int r = 0; r < int'(rp); r++)
      for (int k = int'(ln) - 1; k >= 0; k--)
        if (sel0) q0.push_back(pat[k]); else q1.push_back(pat[k]);
    if (sel0) exp_done0++; else exp_done1++;
    @(posedge clk); #1;
    pattern = pat; len = ln; reps = rp;
    if (sel0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    check("first_state", sel0 ? state0 : state1, 2'b01);
    busy_cnt = 0;
    got_done = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      @(negedge clk);
      if (sel0 ? done0 : done1) got_done = 1'b1;
      else begin
        if (sel0 ? busy0 : busy1) busy_cnt++;
        // Start while busy with a different pattern must not disturb the stream.
        if (poke && c == 2) begin
          pattern = 8'hFF; len = 4'd8;
          if (sel0) start0 = 1'b1; else start1 = 1'b1;
        end
        if (poke && c == 3) begin start0 = 1'b0; start1 = 1'b0; end
      end
    end
    check("done_seen", got_done, 1);
    check("busy_cycles", busy_cnt, exp_busy);
    check("done_state", sel0 ? state0 : state1, 2'b11);
    check("done_busy_low", sel0 ? busy0 : busy1, 0);
    @(negedge clk);
    check("idle_after_done", sel0 ? state0 : state1, 2'b00);
    check("done_one_cycle", sel0 ? done0 : done1, 0);
  endtask

  initial begin
    bit found;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_g1_outs", {dout1, dvalid1, busy1, done1, state1}, 6'b0);
    check("rst_g0_outs", {dout0, dvalid0, busy0, done0, state0}, 6'b0);
    rst = 1'b0;

    // Single shot, then two reps with gap and a start poke while busy
    run_job(1'b0, 8'h0A, 4'd4, 4'd1, 4, 1'b0);
    run_job(1'b0, 8'h0A, 4'd4, 4'd2, 9, 1'b1);

    // Back-to-back full length on the GAP=0 instance
    run_job(1'b1, 8'hB3, 4'd8, 4'd3, 24, 1'b0);

    // Continuous 101 on g0, stopped after the 7th bit
    foreach (q0[i]) ; // no-op keeps queue untouched
    q0.push_back(1); q0.push_back(0); q0.push_back(1);
    q0.push_back(1); q0.push_back(0); q0.push_back(1); q0.push_back(1);
    @(posedge clk); #1;
    pattern = 8'b101; len = 4'd3; reps = 4'd0; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop_state", state0, 2'b00);
    check("stop_outs", {dout0, dvalid0, busy0, done0}, 4'b0);

    // Illegal lengths are ignored
    @(posedge clk); #1;
    pattern = 8'hFF; len = 4'd0; reps = 4'd1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("len0_state", state1, 2'b00);
    check("len0_busy", busy1, 0);
    len = 4'd9; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("len9_state", state1, 2'b00);

    // Reset during GAP: only the first repetition is ever sent
    q1.push_back(1); q1.push_back(0); q1.push_back(1); q1.push_back(0);
    pattern = 8'h0A; len = 4'd4; reps = 4'd2; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (state1 == 2'b10) found = 1'b1;
    end
    check("gap_reached", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_gap_outs", {dout1, dvalid1, busy1, done1, state1}, 6'b0);
    rst = 1'b0;

    // Loopback into the 101 detector
    det_en = 1'b1;
    run_job(1'b0, 8'h15, 4'd5, 4'd1, 5, 1'b0);
    det_en = 1'b0;
    check("det_hit_count", det_hits.size(), 2);
    if (det_hits.size() == 2) begin
      check("det_hit_first", det_hits[0], 3);
      check("det_hit_second", det_hits[1], 5);
    end

    repeat (3) @(negedge clk);
    check("g1_queue_drained", q1.size(), 0);
    check("g0_queue_drained", q0.size(), 0);
    check("g1_done_count", ndone1, exp_done1);
    check("g0_done_count", ndone0, exp_done0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
